// File: rtl/fft_power_stream.sv
// Streams FFT bins into per-bin power (re^2 + im^2) with bin index, frame-end pulse
// and a sticky framing-error flag; two register stages, one bin per cycle.
module fft_power_stream #(
    parameter int unsigned N_FFT = 512,
    parameter int unsigned IN_W  = 16,
    localparam int unsigned K_W  = $clog2(N_FFT)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic signed [IN_W-1:0] re_in,
    input  logic signed [IN_W-1:0] im_in,
    input  logic                   valid_in,
    input  logic                   last_in,
    input  logic                   err_clr_in,
    output logic [2*IN_W-1:0]      power_out,
    output logic [K_W-1:0]         k_out,
    output logic                   valid_out,
    output logic                   frame_done_out,
    output logic                   sync_err_out
);

    localparam int unsigned SQ_W  = 2 * IN_W - 1;
    localparam int unsigned PWR_W = 2 * IN_W;
    localparam logic [K_W-1:0] K_MAX = K_W'(N_FFT - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;

    logic [SQ_W-1:0]  re_sq_q, re_sq_d;
    logic [SQ_W-1:0]  im_sq_q, im_sq_d;
    logic [K_W-1:0]   k1_q, k1_d;
    logic             v1_q, v1_d;
    logic             fd1_q, fd1_d;
    logic             err1_q, err1_d;

    logic [PWR_W-1:0] power_q, power_d;
    logic [K_W-1:0]   k2_q, k2_d;
    logic             v2_q, v2_d;
    logic             fd2_q, fd2_d;
    logic             err_q, err_d;

    logic                   at_max;
    logic                   bin_end;
    logic                   bin_err;
    logic signed [PWR_W-1:0] re_prod;
    logic signed [PWR_W-1:0] im_prod;

    // Frame tracking: a bin closes the frame on last_in or on reaching the top index;
    // the two disagreeing marks a framing error on that bin.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        at_max  = (k_q == K_MAX);
        bin_end = valid_in && (last_in || at_max);
        bin_err = valid_in && (last_in != at_max);
        case (state_q)
            ST_IDLE: begin
                if (valid_in && !bin_end) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (bin_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (valid_in) begin
            k_d = bin_end ? '0 : k_q + K_W'(1);
        end
    end

    // Stage 1: squares and sideband, zeroed on idle cycles so stage 2 emits zeros.
    always_comb begin
        re_prod = re_in * re_in;
        im_prod = im_in * im_in;
        v1_d    = valid_in;
        re_sq_d = valid_in ? SQ_W'(re_prod) : '0;
        im_sq_d = valid_in ? SQ_W'(im_prod) : '0;
        k1_d    = valid_in ? k_q : '0;
        fd1_d   = bin_end;
        err1_d  = bin_err;
    end

    // Stage 2: sum and sticky error; a new error outranks a simultaneous clear.
    always_comb begin
        v2_d    = v1_q;
        power_d = {1'b0, re_sq_q} + {1'b0, im_sq_q};
        k2_d    = k1_q;
        fd2_d   = v1_q && fd1_q;
        err_d   = err_q;
        if (v1_q && err1_q) begin
            err_d = 1'b1;
        end else if (err_clr_in) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            re_sq_q <= '0;
            im_sq_q <= '0;
            k1_q    <= '0;
            v1_q    <= 1'b0;
            fd1_q   <= 1'b0;
            err1_q  <= 1'b0;
            power_q <= '0;
            k2_q    <= '0;
            v2_q    <= 1'b0;
            fd2_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
            k1_q    <= k1_d;
            v1_q    <= v1_d;
            fd1_q   <= fd1_d;
            err1_q  <= err1_d;
            power_q <= power_d;
            k2_q    <= k2_d;
            v2_q    <= v2_d;
            fd2_q   <= fd2_d;
            err_q   <= err_d;
        end
    end

    assign power_out      = power_q;
    assign k_out          = k2_q;
    assign valid_out      = v2_q;
    assign frame_done_out = fd2_q;
    assign sync_err_out   = err_q;

endmodule

// File: doc/fft_power_stream.md
FFT_POWER_STREAM -- requirements
Module: fft_power_stream

Interface
REQ-001 SHALL have parameter N_FFT, default 512, meaning bins per frame (power of two; K_W = log2(N_FFT)).
REQ-002 SHALL have parameter IN_W, default 16, meaning signed width of each FFT real/imag sample.
REQ-003 SHALL have port clk_in  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port re_in  input  IN_W  signed real part of current FFT bin.
REQ-006 SHALL have port im_in  input  IN_W  signed imaginary part of current FFT bin.
REQ-007 SHALL have port valid_in  input  1  re_in/im_in/last_in valid this cycle.
REQ-008 SHALL have port last_in  input  1  marks final bin of a frame (sampled only with valid_in).
REQ-009 SHALL have port err_clr_in  input  1  synchronous clear of sync_err_out.
REQ-010 SHALL have port power_out  output  2*IN_W  unsigned re^2+im^2 for bin k_out (feeds triangular_filter power_in).
REQ-011 SHALL have port k_out  output  K_W  bin index of power_out (feeds triangular_filter k_in).
REQ-012 SHALL have port valid_out  output  1  power_out/k_out valid.
REQ-013 SHALL have port frame_done_out  output  1  one-cycle pulse coincident with the last bin of a frame on valid_out.
REQ-014 SHALL have port sync_err_out  output  1  sticky framing error flag.

Function
REQ-015 SHALL keep an internal bin counter k (K_W bits) advancing by 1 only on cycles with valid_in=1; gaps in valid_in are allowed and do not change k.
REQ-016 SHALL implement states IDLE (k=0, no frame open) and STREAM (k>0); IDLE->STREAM on valid_in with last_in=0; STREAM->IDLE on valid_in with last_in=1 or on valid_in at k=N_FFT-1.
REQ-017 SHALL, in IDLE, treat valid_in with last_in=1 as a one-bin frame: emit k=0, pulse frame_done_out, set sync_err_out (N_FFT>1), remain IDLE.
REQ-018 SHALL, on valid_in with last_in=1 at k=N_FFT-1, end the frame normally: k returns to 0, frame_done_out asserted with that bin, sync_err_out unchanged.
REQ-019 SHALL, on valid_in with last_in=1 at k<N_FFT-1 (short frame), return k to 0, assert frame_done_out with that bin, and set sync_err_out.
REQ-020 SHALL, on valid_in at k=N_FFT-1 with last_in=0 (missing last), wrap k to 0, assert frame_done_out with that bin, and set sync_err_out.
REQ-021 SHALL compute squares as full-precision signed products (IN_W x IN_W -> 2*IN_W-1 bits unsigned magnitude) and sum into 2*IN_W bits unsigned without truncation or saturation; worst case (-2^(IN_W-1))^2*2 = 2^(2*IN_W-1) fits.
REQ-022 SHALL be fully pipelined, two register stages: stage 1 registers re^2, im^2, k, valid, frame_done; stage 2 registers sum and aligned sideband; latency valid_in -> valid_out exactly 2 cycles, throughput one bin per cycle.
REQ-023 SHALL drive power_out=0 and k_out=0 on every cycle where valid_out=0.
REQ-024 SHALL assert frame_done_out only on cycles where valid_out=1.
REQ-025 SHALL set sync_err_out on the cycle the offending bin appears on valid_out (2-cycle latency, aligned with frame_done_out).
REQ-026 SHALL clear sync_err_out on err_clr_in=1 at the next clock edge; a simultaneous new error has priority and keeps sync_err_out=1.
REQ-027 SHALL ignore last_in when valid_in=0.

Reset
REQ-028 SHALL, while rst_in=0, immediately force power_out=0, k_out=0, valid_out=0, frame_done_out=0, sync_err_out=0, k=0, state IDLE, and clear all pipeline valid bits.
REQ-029 SHALL discard any partially streamed frame on reset; the first valid_in after rst_in returns to 1 is bin 0.
REQ-030 SHALL release reset synchronously to clk_in (no output change until the first rising edge with rst_in=1).

Verification
REQ-031 SHALL cover full frame: 512 consecutive valid bins re=3, im=-4, last_in on bin 511 -> 512 outputs power_out=25, k_out=0..511, valid_out 2 cycles after each input, frame_done_out only with k_out=511, sync_err_out=0.
REQ-032 SHALL cover extremes: re=-32768, im=-32768 -> power_out=32'h8000_0000; re=32767, im=0 -> 32'h3FFF_0001.
REQ-033 SHALL cover gapped input: valid_in toggling 1/0 over 512 bins -> k_out contiguous 0..511 with identical gaps on valid_out, power_out=0 and k_out=0 in gaps.
REQ-034 SHALL cover short frame (last_in at bin 100) and missing last (512 bins, no last_in) -> frame_done_out with k_out=100 / 511, sync_err_out=1 on that same cycle, next frame starts at k_out=0; err_clr_in then drops sync_err_out to 0.
REQ-035 SHALL cover reset mid-frame: rst_in=0 at bin 200 for 2 cycles -> all outputs 0 asynchronously, in-flight bins not emitted, next input emitted as k_out=0.
REQ-036 SHALL cover end-to-end: drive triangular_filter (START=165, PEAK=206, STOP=256) from power_out/k_out with flat re=1000, im=0 -> filter output matches the same stimulus applied directly as power_in=1000000.
